// File: rtl/sudoku_solve_sequencer_if.sv
// sudoku_solve_sequencer_if: evaluate-request handshake between the sequencer
// and the constraint-propagation datapath.
interface sudoku_solve_sequencer_if;
   logic       unit_req;
   logic [4:0] unit_sel;
   logic       unit_ack;
   logic       unit_changed;
   logic       unit_solved;
   logic       unit_error;
   modport master (output unit_req, unit_sel, input unit_ack, unit_changed, unit_solved, unit_error);
   modport slave  (input unit_req, unit_sel, output unit_ack, unit_changed, unit_solved, unit_error);
endinterface

// File: rtl/sudoku_solve_sequencer.sv
// sudoku_solve_sequencer: sweeps row/column/box units in passes until the board
// is solved, propagation stalls, a contradiction appears, an abort or the pass limit.
module sudoku_solve_sequencer #(
   parameter int NUM_UNITS  = 27,
   parameter int MAX_PASSES = 16,
   parameter int PASS_W     = 5
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     start,
   input  logic                     abort,
   sudoku_solve_sequencer_if.master unit,
   output logic                     busy,
   output logic                     done,
   output logic [2:0]               status,
   output logic [PASS_W-1:0]        pass_count,
   output logic                     irq
);
   typedef enum logic [1:0] {IDLE, WAIT, NEXT, DONE} state_t;
   localparam logic [2:0] ST_SOLVED = 3'd1, ST_STALLED = 3'd2, ST_ERROR = 3'd3,
                          ST_LIMIT = 3'd4, ST_ABORTED = 3'd5;
   state_t            state, state_n;
   logic [4:0]        sel, sel_n;
   logic [PASS_W-1:0] pass_n, pass_inc;
   logic              any_changed, any_changed_n, all_solved, all_solved_n;
   logic              err, err_n, abort_pend, abort_pend_n;
   logic              done_n, req;
   logic [2:0]        status_n;
   assign pass_inc      = pass_count + 1'b1;
   assign unit.unit_req = req;
   assign unit.unit_sel = sel;
   always_comb begin
      state_n       = state;
      sel_n         = sel;
      pass_n        = pass_count;
      any_changed_n = any_changed;
      all_solved_n  = all_solved;
      err_n         = err;
      abort_pend_n  = abort_pend | (abort && state != IDLE);
      done_n        = done;
      status_n      = status;
      case (state)
         IDLE: if (start) begin
            state_n       = WAIT;
            sel_n         = '0;
            pass_n        = '0;
            done_n        = 1'b0;
            status_n      = '0;
            any_changed_n = 1'b0;
            all_solved_n  = 1'b1;
            err_n         = 1'b0;
            abort_pend_n  = 1'b0;
         end
         WAIT: if (unit.unit_ack) begin
            state_n       = NEXT;
            any_changed_n = any_changed | unit.unit_changed;
            all_solved_n  = all_solved & unit.unit_solved;
            err_n         = err | unit.unit_error;
         end
         NEXT: begin
            // abort landing in this very cycle still counts, hence the raw input too
            if (err) begin
               state_n  = DONE;
               status_n = ST_ERROR;
            end else if (abort_pend || abort) begin
               state_n  = DONE;
               status_n = ST_ABORTED;
            end else if (sel < 5'(NUM_UNITS - 1)) begin
               state_n = WAIT;
               sel_n   = sel + 5'd1;
            end else begin
               pass_n = pass_inc;
               if (all_solved) begin
                  state_n  = DONE;
                  status_n = ST_SOLVED;
               end else if (!any_changed) begin
                  state_n  = DONE;
                  status_n = ST_STALLED;
               end else if (pass_inc == PASS_W'(MAX_PASSES)) begin
                  state_n  = DONE;
                  status_n = ST_LIMIT;
               end else begin
                  state_n       = WAIT;
                  sel_n         = '0;
                  any_changed_n = 1'b0;
                  all_solved_n  = 1'b1;
               end
            end
         end
         DONE: state_n = IDLE;
      endcase
      if (state_n == DONE) done_n = 1'b1;
   end
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         sel         <= '0;
         pass_count  <= '0;
         any_changed <= 1'b0;
         all_solved  <= 1'b0;
         err         <= 1'b0;
         abort_pend  <= 1'b0;
         done        <= 1'b0;
         status      <= '0;
         req         <= 1'b0;
         busy        <= 1'b0;
         irq         <= 1'b0;
      end else begin
         state       <= state_n;
         sel         <= sel_n;
         pass_count  <= pass_n;
         any_changed <= any_changed_n;
         all_solved  <= all_solved_n;
         err         <= err_n;
         abort_pend  <= abort_pend_n;
         done        <= done_n;
         status      <= status_n;
         req         <= state_n == WAIT;
         busy        <= state_n == WAIT || state_n == NEXT;
         irq         <= state_n == DONE;
      end
   end
endmodule

// File: tb/tb_sudoku_solve_sequencer.sv
// tb_sudoku_solve_sequencer: directed solves against a scripted datapath responder;
// expected completions are queued at start and checked when irq fires.
module tb_sudoku_solve_sequencer;
   typedef struct {
      int st;
      int pc;
   } exp_t;
   logic       clk, rst, start, abort;
   logic       resp_ack, spur_ack, chg, sol, er;
   logic       busy, done, irq;
   logic [2:0] status;
   logic [4:0] pass_count;
   int         n_checks = 0, n_fail = 0;
   int         mode = 1, ack_delay = 0, ack_count = 0, wait_cnt = 0, irq_seen = 0;
   exp_t       q[$];
   sudoku_solve_sequencer_if unit_if();
   assign unit_if.unit_ack     = resp_ack | spur_ack;
   assign unit_if.unit_changed = chg | spur_ack;
   assign unit_if.unit_solved  = sol;
   assign unit_if.unit_error   = er | spur_ack;
   sudoku_solve_sequencer #(.NUM_UNITS(27), .MAX_PASSES(3), .PASS_W(5)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort), .unit(unit_if.master),
      .busy(busy), .done(done), .status(status), .pass_count(pass_count), .irq(irq)
   );
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask
   // {changed, solved, error} the scripted datapath reports for a unit
   function automatic logic [2:0] flags(input int m, input int p, input int u);
      case (m)
         1:       return 3'b010;
         2:       return {p == 0 && u == 5, 2'b00};
         3:       return {2'b00, p == 0 && u == 12};
         default: return {u == 0, 2'b00};
      endcase
   endfunction
   initial begin
      logic [2:0] f;
      resp_ack = 1'b0;
      {chg, sol, er} = 3'b000;
      forever begin
         @(negedge clk);
         resp_ack = 1'b0;
         {chg, sol, er} = 3'b000;
         if (unit_if.unit_req && !rst) begin
            if (wait_cnt >= ack_delay) begin
               check("unit_sel", unit_if.unit_sel, ack_count % 27);
               f = flags(mode, ack_count / 27, ack_count % 27);
               resp_ack = 1'b1;
               {chg, sol, er} = f;
               ack_count++;
               wait_cnt = 0;
            end else wait_cnt++;
         end else wait_cnt = 0;
      end
   end
   always @(negedge clk) begin
      exp_t e;
      if (irq) begin
         irq_seen++;
         if (q.size() == 0) check("unexpected_irq", 1, 0);
         else begin
            e = q.pop_front();
            check("status", status, e.st);
            check("pass_count", pass_count, e.pc);
            check("done_at_irq", done, 1);
            check("busy_at_irq", busy, 0);
         end
      end
   end
   task automatic start_solve(input int m, input int dly, input int st, input int pc);
      exp_t e;
      mode = m;
      ack_delay = dly;
      ack_count = 0;
      irq_seen = 0;
      e.st = st;
      e.pc = pc;
      @(negedge clk);
      start = 1'b1;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("done_after_start", done, 0);
      check("status_after_start", status, 0);
   endtask
   task automatic wait_done(input int limit);
      bit seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      if (!seen) check("done_timeout", 0, 1);
      repeat (3) @(negedge clk);
      check("irq_once", irq_seen, 1);
      check("req_idle", unit_if.unit_req, 0);
   endtask
   task automatic check_all_zero(input string tag);
      check({tag, "_req"}, unit_if.unit_req, 0);
      check({tag, "_sel"}, unit_if.unit_sel, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_status"}, status, 0);
      check({tag, "_pass"}, pass_count, 0);
      check({tag, "_irq"}, irq, 0);
   endtask
   initial begin
      bit hit;
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      spur_ack = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      // full sweep, every unit solved on first pass
      start_solve(1, 1, 1, 1);
      wait_done(2000);
      check("acks_solved", ack_count, 27);
      // one change in pass 1, nothing in pass 2 -> stalled
      start_solve(2, 0, 2, 2);
      wait_done(2000);
      check("acks_stalled", ack_count, 54);
      // contradiction on unit 12 stops before unit 13
      start_solve(3, 0, 3, 0);
      wait_done(2000);
      check("acks_error", ack_count, 13);
      // keeps changing -> pass limit (3 in this bench)
      start_solve(4, 0, 4, 3);
      wait_done(2000);
      check("acks_limit", ack_count, 81);
      // abort while unit 7 is outstanding with a slow datapath
      start_solve(4, 10, 5, 0);
      hit = 1'b0;
      for (int i = 0; i < 500 && !hit; i++) begin
         @(negedge clk);
         hit = unit_if.unit_req && unit_if.unit_sel == 5'd7;
      end
      check("reach_unit7", hit, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      repeat (3) @(negedge clk);
      check("req_held_on_abort", unit_if.unit_req, 1);
      check("sel_held_on_abort", unit_if.unit_sel, 7);
      wait_done(2000);
      check("acks_abort", ack_count, 8);
      start_solve(1, 0, 1, 1);
      wait_done(2000);
      // asynchronous reset while a request is outstanding
      start_solve(1, 0, 1, 1);
      hit = 1'b0;
      for (int i = 0; i < 500 && !hit; i++) begin
         @(negedge clk);
         hit = unit_if.unit_req && unit_if.unit_sel == 5'd3;
      end
      check("reach_unit3", hit, 1);
      #2 rst = 1'b1;
      #1 check_all_zero("async_rst");
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      spur_ack = 1'b1;
      repeat (3) @(negedge clk);
      spur_ack = 1'b0;
      check("spur_busy", busy, 0);
      check("spur_req", unit_if.unit_req, 0);
      check("spur_done", done, 0);
      check("spur_status", status, 0);
      // start while busy must not restart the sweep
      start_solve(1, 0, 1, 1);
      repeat (6) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(2000);
      check("acks_start_busy", ack_count, 27);
      check("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
